// File: rtl/pipeline_divider.sv
// ----------------------------------------------------------------------------
// pipeline_divider
//
// Fully pipelined unsigned restoring divider: 28-bit dividend / 20-bit
// divisor -> 8-bit quotient. Each of the 8 register stages resolves one
// quotient bit, MSB first. A new operand pair can enter every clock. Each
// result leaves exactly 8 clocks after its operands were sampled.
//
// Ports
//   clock     in   1   rising-edge clock for all registers
//   reset_n   in   1   asynchronous active-low reset
//   start     in   1   operand-valid; divided/divisor sampled when high
//   divided   in  28   unsigned dividend
//   divisor   in  20   unsigned divisor
//   q         out  8   quotient (8'hFF on divide-by-zero or overflow)
//   StartOut  out  1   result-valid, one cycle per accepted start
//
// Handshake: valid-only, no ready. start qualifies the operands on the edge
// where it is high. StartOut qualifies q for the single cycle it is high.
// The pipeline never stalls, so the consumer must take every result as it
// appears. Between results, q keeps the last delivered value.
// ----------------------------------------------------------------------------
module pipeline_divider (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [27:0] divided,
    input  logic [19:0] divisor,
    output logic [7:0]  q,
    output logic        StartOut
);

    localparam int STAGES = 8;

    // Register bank, indexed by the stage that produced the value.
    // word_q holds a shared shift register. Its upper bits are the dividend
    // bits not yet consumed. Its lower bits are the quotient bits produced
    // so far. Each stage shifts the next dividend bit out of the top and
    // shifts its quotient bit in at the bottom. After stage 8 the register
    // holds only the quotient.
    // rem_q and dvs_q are not needed after stage 8, so they stop at stage 7.
    logic [STAGES:1] vld_q;
    logic [STAGES:1] err_q;
    logic [7:0]      word_q [1:STAGES];
    logic [19:0]     rem_q  [1:STAGES-1];
    logic [19:0]     dvs_q  [1:STAGES-1];

    // Stage inputs. Stage 1 reads the ports; stage s>1 reads register s-1.
    logic [STAGES:1] in_vld;
    logic [STAGES:1] in_err;
    logic [7:0]      in_word [1:STAGES];
    logic [19:0]     in_rem  [1:STAGES];
    logic [19:0]     in_dvs  [1:STAGES];

    // Per-stage trial value and compare result.
    logic [20:0]     trial   [1:STAGES];
    logic [STAGES:1] ge;

    // ------------------------------------------------------------------
    // Stage input selection
    // ------------------------------------------------------------------
    always_comb begin
        in_vld = '0;
        in_err = '0;
        for (int s = 1; s <= STAGES; s++) begin
            in_word[s] = '0;
            in_rem[s]  = '0;
            in_dvs[s]  = '0;
        end

        // Stage 1 seeds the remainder with the top 20 dividend bits.
        // If that seed already reaches the divisor, the quotient needs more
        // than 8 bits. This test also catches divisor == 0.
        in_vld[1]  = start;
        in_err[1]  = (divided[27:8] >= divisor);
        in_word[1] = divided[7:0];
        in_rem[1]  = divided[27:8];
        in_dvs[1]  = divisor;

        for (int s = 2; s <= STAGES; s++) begin
            in_vld[s]  = vld_q[s-1];
            in_err[s]  = err_q[s-1];
            in_word[s] = word_q[s-1];
            in_rem[s]  = rem_q[s-1];
            in_dvs[s]  = dvs_q[s-1];
        end
    end

    // ------------------------------------------------------------------
    // Restoring step: trial = {R, next dividend bit}; subtract if it fits.
    // ------------------------------------------------------------------
    always_comb begin
        ge = '0;
        for (int s = 1; s <= STAGES; s++) begin
            trial[s] = {in_rem[s], in_word[s][7]};
            ge[s]    = (trial[s] >= {1'b0, in_dvs[s]});
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers. Data moves every cycle whether or not it is
    // valid; only the valid bits give it meaning.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int s = 1; s <= STAGES; s++) begin
                word_q[s] <= '0;
            end
            for (int s = 1; s < STAGES; s++) begin
                rem_q[s] <= '0;
                dvs_q[s] <= '0;
            end
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                vld_q[s]  <= in_vld[s];
                err_q[s]  <= in_err[s];
                word_q[s] <= {in_word[s][6:0], ge[s]};
            end
            // With no error, the new remainder is below the divisor, so it
            // fits in 20 bits. A 20-bit subtract therefore gives the exact
            // value, even when the trial used bit 20.
            for (int s = 1; s < STAGES; s++) begin
                rem_q[s] <= ge[s] ? (trial[s][19:0] - in_dvs[s])
                                  : trial[s][19:0];
                dvs_q[s] <= in_dvs[s];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: q only updates on a valid result and holds otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            StartOut <= 1'b0;
            q        <= '0;
        end else begin
            StartOut <= vld_q[STAGES];
            if (vld_q[STAGES]) begin
                q <= err_q[STAGES] ? 8'hFF : word_q[STAGES];
            end
        end
    end

endmodule

// File: tb/tb_pipeline_divider.sv
// ----------------------------------------------------------------------------
// tb_pipeline_divider
//
// Directed and random stimulus for pipeline_divider. Expected quotients come
// from plain integer division. Each expected result is queued together with
// the cycle in which it must appear. StartOut and q are checked on every
// falling edge.
// ----------------------------------------------------------------------------
module tb_pipeline_divider;

    localparam int LATENCY = 8;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [27:0] divided;
    logic [19:0] divisor;
    logic [7:0]  q;
    logic        StartOut;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Scoreboard: expected quotient and the cycle it is due.
    logic [7:0] exp_q[$];
    int         due_q[$];
    logic [7:0] held_q;

    pipeline_divider dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .divided  (divided),
        .divisor  (divisor),
        .q        (q),
        .StartOut (StartOut)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] model(input logic [27:0] a, input logic [19:0] b);
        longint qq;
        if (b == 20'd0) return 8'hFF;
        qq = longint'(a) / longint'(b);
        if (qq > 255) return 8'hFF;
        return qq[7:0];
    endfunction

    // ---------------- checks ----------------
    task automatic check_outputs();
        logic       exp_v;
        logic [7:0] val;
        exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
        n_checks++;
        assert (StartOut === exp_v) else begin
            n_fail++;
            $error("FAIL startout cyc=%0d observed=%b expected=%b", cyc, StartOut, exp_v);
        end
        if (exp_v) begin
            val = exp_q.pop_front();
            void'(due_q.pop_front());
            held_q = val;
        end
        n_checks++;
        assert (q === held_q) else begin
            n_fail++;
            $error("FAIL q cyc=%0d observed=%0d expected=%0d", cyc, q, held_q);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge: drive inputs, take one rising edge, check.
    task automatic step(input logic s, input logic [27:0] a, input logic [19:0] b);
        start   = s;
        divided = a;
        divisor = b;
        @(posedge clock);
        cyc++;
        if (s && reset_n) begin
            exp_q.push_back(model(a, b));
            due_q.push_back(cyc + LATENCY);
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 28'($urandom), 20'($urandom));
        end
    endtask

    // Reset asserted between edges. The outputs must clear at once, and
    // everything still in flight is dropped.
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        assert (StartOut === 1'b0) else begin
            n_fail++;
            $error("FAIL rst_startout observed=%b expected=0", StartOut);
        end
        n_checks++;
        assert (q === 8'h00) else begin
            n_fail++;
            $error("FAIL rst_q observed=%0d expected=0", q);
        end
        exp_q.delete();
        due_q.delete();
        held_q = 8'h00;
        start  = 1'b1;
        repeat (2) begin
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        start   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [19:0] b;
        logic [27:0] a;
        int          sel;

        reset_n = 1'b0;
        start   = 1'b0;
        divided = '0;
        divisor = '0;
        held_q  = 8'h00;
        #1;
        n_checks++;
        assert (StartOut === 1'b0 && q === 8'h00) else begin
            n_fail++;
            $error("FAIL init_reset observed=%b/%0d expected=0/0", StartOut, q);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Single operation, then silence.
        step(1'b1, 28'd100, 20'd5);
        idle(12);

        // Back-to-back stream.
        step(1'b1, 28'd101, 20'd5);
        step(1'b1, 28'd21,  20'd3);
        step(1'b1, 28'd300, 20'd3);
        idle(10);

        // Bubble in the middle.
        step(1'b1, 28'd100, 20'd5);
        step(1'b0, 28'($urandom), 20'($urandom));
        step(1'b1, 28'd21,  20'd3);
        idle(10);

        // Error and boundary cases.
        step(1'b1, 28'd50,        20'd0);
        step(1'b1, 28'd5000,      20'd5);
        step(1'b1, 28'd1279,      20'd5);
        step(1'b1, 28'd0,         20'd7);
        step(1'b1, 28'd255,       20'd1);
        step(1'b1, 28'd268435455, 20'd1048575);
        step(1'b1, 28'd1280,      20'd5);
        idle(10);

        // Random traffic, quotients mostly in range.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            b   = 20'($urandom_range(1, 20'hFFFFF));
            if (sel == 0) begin
                b = 20'd0;
                a = 28'($urandom);
            end else if (sel == 1) begin
                a = 28'($urandom);
            end else if (sel == 2) begin
                b = 20'($urandom_range(1, 16));
                a = 28'(longint'(b) * 256 + $urandom_range(0, 300));
            end else begin
                a = 28'(longint'(b) * $urandom_range(0, 255) + $urandom_range(0, int'(b) - 1));
            end
            step(($urandom_range(0, 3) != 0), a, b);
        end
        idle(10);

        // Reset with operations in flight: none of them may come out.
        step(1'b1, 28'd100, 20'd5);
        step(1'b1, 28'd200, 20'd5);
        step(1'b1, 28'd300, 20'd5);
        step(1'b1, 28'd400, 20'd5);
        async_reset();
        idle(12);

        // Normal operation after the reset.
        step(1'b1, 28'd77,  20'd7);
        step(1'b1, 28'd999, 20'd4);
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
